// File: rtl/lane_judge.sv
`default_nettype none
// ============================================================================
// Module   : lane_judge
// Brief    : Four-lane note judge. Tracks in-flight notes as per-lane frame
//            countdowns, grades key presses against an early/late window and
//            presents per-frame hit points and miss counts on each frame tick.
// Revision : 1.0 - initial release
// ============================================================================
module lane_judge #(
  parameter int TRAVEL = 60,  // frames from spawn to target (<= 100)
  parameter int EARLY  = 4,   // judged frames before target
  parameter int LATE   = 4,   // judged frames after target
  parameter int DEPTH  = 4    // notes held per lane
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       frame_clk,
  input  logic [3:0] note_spawn,
  input  logic [3:0] key,
  output logic [3:0] hit0,
  output logic [3:0] hit1,
  output logic [3:0] hit2,
  output logic [3:0] hit3,
  output logic [3:0] miss0,
  output logic [3:0] miss1,
  output logic [3:0] miss2,
  output logic [3:0] miss3,
  output logic [3:0] overflow
);

  localparam int                CW       = $clog2(DEPTH + 1);
  localparam logic signed [7:0] c_TRAVEL = 8'(TRAVEL);
  localparam logic signed [7:0] c_EARLY  = 8'(EARLY);
  localparam logic signed [7:0] c_LATE_N = 8'(-LATE);
  localparam logic [CW-1:0]     c_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0]     c_ONE    = CW'(1);

  logic        frame_clk_q;
  logic        w_tick;
  logic [3:0]  key_s1_q;
  logic [3:0]  key_s2_q;
  logic [3:0]  key_prev_q;
  logic [3:0]  w_press;
  logic [15:0] w_hit_all;
  logic [15:0] w_miss_all;

  // Frame clock history for rising-edge detection in the Clk domain.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) frame_clk_q <= 1'b0;
    else          frame_clk_q <= frame_clk;
  end

  assign w_tick = frame_clk & ~frame_clk_q;

  // Two-flop key synchronizer plus one history flop for press edge detect.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      key_s1_q   <= '0;
      key_s2_q   <= '0;
      key_prev_q <= '0;
    end else begin
      key_s1_q   <= key;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
    end
  end

  assign w_press = key_s2_q & ~key_prev_q;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic signed [7:0] q_q [DEPTH];
    logic signed [7:0] q_d [DEPTH];
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        hacc_q, hacc_d;
    logic [3:0]        macc_q, macc_d;
    logic [3:0]        hit_q, hit_d;
    logic [3:0]        miss_q, miss_d;
    logic              ovf_q, ovf_d;

    logic signed [7:0] w_head;
    logic              w_valid;
    logic              w_in_win;
    logic              w_hit;
    logic              w_stray;
    logic              w_expire;
    logic              w_pop;
    logic              w_miss_ev;
    logic [1:0]        w_pts;
    logic [CW-1:0]     w_cnt_pop;
    logic [4:0]        w_hsum;
    logic [4:0]        w_msum;

    // Judge the head (pre-decrement value) against this cycle's press/tick.
    // Expiry uses <= so that notes spawned in the same frame, which share a
    // countdown value, cannot slip below the window and linger forever.
    always_comb begin
      w_head    = q_q[0];
      w_valid   = (cnt_q != '0);
      w_in_win  = w_valid && (w_head >= c_LATE_N) && (w_head <= c_EARLY);
      w_hit     = w_press[l] && w_in_win;
      w_stray   = w_press[l] && !w_in_win;
      w_expire  = w_tick && !w_press[l] && w_valid && (w_head <= c_LATE_N);
      w_pop     = w_hit || w_expire;
      w_miss_ev = w_stray || w_expire;
      if (!w_hit)                                  w_pts = 2'd0;
      else if (w_head == 8'sd0)                    w_pts = 2'd3;
      else if (w_head == 8'sd1 || w_head == -8'sd1) w_pts = 2'd2;
      else                                         w_pts = 2'd1;
    end

    // Queue update: pop the head, age survivors on tick, then append spawn.
    always_comb begin
      q_d       = q_q;
      ovf_d     = ovf_q;
      w_cnt_pop = cnt_q;
      if (w_pop) begin
        for (int j = 0; j < DEPTH - 1; j++) q_d[j] = q_q[j + 1];
        q_d[DEPTH - 1] = '0;
        w_cnt_pop      = cnt_q - c_ONE;
      end
      if (w_tick) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (CW'(j) < w_cnt_pop) q_d[j] = q_d[j] - 8'sd1;
        end
      end
      cnt_d = w_cnt_pop;
      if (note_spawn[l]) begin
        if (cnt_q == c_DEPTH) begin
          ovf_d = 1'b1;
        end else begin
          for (int j = 0; j < DEPTH; j++) begin
            if (CW'(j) == w_cnt_pop) q_d[j] = c_TRAVEL;
          end
          cnt_d = w_cnt_pop + c_ONE;
        end
      end
    end

    // Saturating frame accumulators; a tick publishes and restarts them.
    always_comb begin
      w_hsum = {1'b0, hacc_q} + {3'b000, w_pts};
      w_msum = {1'b0, macc_q} + {4'b0000, w_miss_ev};
      hit_d  = hit_q;
      miss_d = miss_q;
      if (w_tick) begin
        hit_d  = hacc_q;
        miss_d = macc_q;
        hacc_d = {2'b00, w_pts};
        macc_d = {3'b000, w_miss_ev};
      end else begin
        hacc_d = w_hsum[4] ? 4'hF : w_hsum[3:0];
        macc_d = w_msum[4] ? 4'hF : w_msum[3:0];
      end
    end

    // Lane state registers.
    always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int j = 0; j < DEPTH; j++) q_q[j] <= '0;
        cnt_q  <= '0;
        hacc_q <= '0;
        macc_q <= '0;
        hit_q  <= '0;
        miss_q <= '0;
        ovf_q  <= 1'b0;
      end else begin
        q_q    <= q_d;
        cnt_q  <= cnt_d;
        hacc_q <= hacc_d;
        macc_q <= macc_d;
        hit_q  <= hit_d;
        miss_q <= miss_d;
        ovf_q  <= ovf_d;
      end
    end

    assign w_hit_all[4*l +: 4]  = hit_q;
    assign w_miss_all[4*l +: 4] = miss_q;
    assign overflow[l]          = ovf_q;
  end

  assign hit0  = w_hit_all[3:0];
  assign hit1  = w_hit_all[7:4];
  assign hit2  = w_hit_all[11:8];
  assign hit3  = w_hit_all[15:12];
  assign miss0 = w_miss_all[3:0];
  assign miss1 = w_miss_all[7:4];
  assign miss2 = w_miss_all[11:8];
  assign miss3 = w_miss_all[15:12];

endmodule
`default_nettype wire

// File: tb/tb_lane_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_lane_judge
// Brief    : Self-checking bench for lane_judge: directed scenarios plus a
//            randomized phase checked against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lane_judge;

  localparam int TRAVEL = 60;
  localparam int EARLY  = 4;
  localparam int LATE   = 4;
  localparam int DEPTH  = 4;

  logic       Clk = 1'b0;
  logic       reset_n;
  logic       frame_clk;
  logic [3:0] note_spawn;
  logic [3:0] key;
  logic [3:0] hit0, hit1, hit2, hit3;
  logic [3:0] miss0, miss1, miss2, miss3;
  logic [3:0] overflow;

  logic [3:0] hit_v  [4];
  logic [3:0] miss_v [4];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         mq [4][$];
  int         m_hacc [4];
  int         m_macc [4];
  int         m_hit  [4];
  int         m_miss [4];
  bit         m_ovf  [4];
  logic [3:0] kh1, kh2, kh3;
  logic       fc_prev;

  lane_judge #(.TRAVEL(TRAVEL), .EARLY(EARLY), .LATE(LATE), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .reset_n(reset_n), .frame_clk(frame_clk),
    .note_spawn(note_spawn), .key(key),
    .hit0(hit0), .hit1(hit1), .hit2(hit2), .hit3(hit3),
    .miss0(miss0), .miss1(miss1), .miss2(miss2), .miss3(miss3),
    .overflow(overflow)
  );

  always #5 Clk = ~Clk;

  assign hit_v[0]  = hit0;
  assign hit_v[1]  = hit1;
  assign hit_v[2]  = hit2;
  assign hit_v[3]  = hit3;
  assign miss_v[0] = miss0;
  assign miss_v[1] = miss1;
  assign miss_v[2] = miss2;
  assign miss_v[3] = miss3;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 4; l++) begin
      mq[l].delete();
      m_hacc[l] = 0; m_macc[l] = 0; m_hit[l] = 0; m_miss[l] = 0; m_ovf[l] = 1'b0;
    end
    kh1 = '0; kh2 = '0; kh3 = '0; fc_prev = 1'b0;
  endtask

  // One clock of the game rules, applied to the inputs sampled at this edge.
  task automatic model_cycle();
    logic [3:0] pr;
    bit         tk;
    pr = kh2 & ~kh3;
    tk = frame_clk && !fc_prev;
    kh3 = kh2; kh2 = kh1; kh1 = key; fc_prev = frame_clk;
    for (int l = 0; l < 4; l++) begin
      int pts;
      int mev;
      int a;
      bit full;
      pts = 0; mev = 0;
      full = (mq[l].size() == DEPTH);
      if (pr[l]) begin
        if (mq[l].size() > 0 && mq[l][0] >= -LATE && mq[l][0] <= EARLY) begin
          a   = (mq[l][0] < 0) ? -mq[l][0] : mq[l][0];
          pts = (a == 0) ? 3 : ((a == 1) ? 2 : 1);
          void'(mq[l].pop_front());
        end else begin
          mev = 1;
        end
      end else if (tk && mq[l].size() > 0 && mq[l][0] <= -LATE) begin
        void'(mq[l].pop_front());
        mev = 1;
      end
      if (tk) for (int j = 0; j < mq[l].size(); j++) mq[l][j] = mq[l][j] - 1;
      if (note_spawn[l]) begin
        if (full) m_ovf[l] = 1'b1;
        else      mq[l].push_back(TRAVEL);
      end
      if (tk) begin
        m_hit[l]  = m_hacc[l];
        m_miss[l] = m_macc[l];
        m_hacc[l] = pts;
        m_macc[l] = mev;
      end else begin
        m_hacc[l] = (m_hacc[l] + pts > 15) ? 15 : m_hacc[l] + pts;
        m_macc[l] = (m_macc[l] + mev > 15) ? 15 : m_macc[l] + mev;
      end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    if (reset_n) model_cycle();
    else         model_reset();
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("%s.hit%0d", tag, l),  hit_v[l],    4'(m_hit[l]));
      chk($sformatf("%s.miss%0d", tag, l), miss_v[l],   4'(m_miss[l]));
      chk($sformatf("%s.ovf%0d", tag, l),  {3'b000, overflow[l]}, {3'b000, m_ovf[l]});
    end
  endtask

  task automatic check_zero(input string tag);
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("%s.hit%0d", tag, l),  hit_v[l],  4'h0);
      chk($sformatf("%s.miss%0d", tag, l), miss_v[l], 4'h0);
    end
    chk({tag, ".ovf"}, overflow, 4'h0);
  endtask

  task automatic tick_cycle();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
    check_all("tick");
  endtask

  task automatic spawn_lanes(input logic [3:0] lanes);
    note_spawn = lanes;
    step();
    note_spawn = '0;
  endtask

  task automatic press_key(input int l);
    key[l] = 1'b1;
    step();
    key[l] = 1'b0;
    step();
    step();
  endtask

  task automatic press_with_tick(input int l);
    key[l] = 1'b1;
    step();
    key[l] = 1'b0;
    step();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
  endtask

  initial begin
    reset_n = 1'b0; frame_clk = 1'b0; note_spawn = '0; key = '0;
    model_reset();
    repeat (3) step();
    check_zero("por");
    reset_n = 1'b1;

    // Perfect hit on lane 0
    spawn_lanes(4'b0001);
    repeat (TRAVEL) tick_cycle();
    press_key(0);
    tick_cycle();
    chk("perfect.hit0", hit0, 4'd3);
    chk("perfect.miss0", miss0, 4'd0);
    tick_cycle();
    chk("perfect.next.hit0", hit0, 4'd0);

    // Early/late grades on lanes 1..3
    spawn_lanes(4'b1110);
    repeat (TRAVEL - 5) tick_cycle();
    press_key(3);                 // c = +5: stray
    tick_cycle();
    chk("early5.miss3", miss3, 4'd1);
    chk("early5.hit3", hit3, 4'd0);
    repeat (3) tick_cycle();
    press_key(1);                 // c = +1
    tick_cycle();
    chk("early1.hit1", hit1, 4'd2);
    chk("early1.miss1", miss1, 4'd0);
    repeat (3) tick_cycle();
    press_key(2);                 // c = -3
    tick_cycle();
    chk("late3.hit2", hit2, 4'd1);
    tick_cycle();                 // lane 3 note still queued: expires here
    tick_cycle();
    chk("stay.miss3", miss3, 4'd1);
    tick_cycle();
    chk("stay.after.miss3", miss3, 4'd0);

    // Expiry on lane 2
    spawn_lanes(4'b0100);
    repeat (TRAVEL + LATE) tick_cycle();
    tick_cycle();
    tick_cycle();
    chk("expire.miss2", miss2, 4'd1);
    chk("expire.hit2", hit2, 4'd0);
    tick_cycle();
    chk("expire.empty.miss2", miss2, 4'd0);

    // Overflow and press/tick coincidence on lane 0
    note_spawn = 4'b0001;
    repeat (5) step();
    note_spawn = '0;
    chk("overflow", overflow, 4'b0001);
    repeat (TRAVEL) tick_cycle();
    press_with_tick(0);
    tick_cycle();
    chk("simul.hit0", hit0, 4'd3);
    press_key(0);                 // remaining notes now at c = -2
    tick_cycle();
    chk("simul.decr.hit0", hit0, 4'd1);
    repeat (4) tick_cycle();

    // Stray-press saturation on lane 1
    repeat (20) press_key(1);
    tick_cycle();
    chk("saturate.miss1", miss1, 4'd15);
    tick_cycle();

    // Randomized traffic against the reference model
    for (int c = 0; c < 1600; c++) begin
      frame_clk = ((c % 4) < 2);
      for (int l = 0; l < 4; l++) begin
        note_spawn[l] = ($urandom_range(15) == 0);
        if ($urandom_range(2) == 0) key[l] = ~key[l];
      end
      step();
      check_all("rand");
    end

    // Mid-frame asynchronous reset
    reset_n = 1'b0;
    model_reset();
    #1;
    check_zero("rst.async");
    key = '0; note_spawn = '0; frame_clk = 1'b0;
    repeat (2) step();
    check_zero("rst.held");
    reset_n = 1'b1;
    tick_cycle();
    check_zero("rst.tick1");
    tick_cycle();
    check_zero("rst.tick2");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
